// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, legality check, FSM states.
package alu_seq_pkg;

   localparam int unsigned DEFAULT_DATA_W = 8;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b1000;
   localparam logic [3:0] OP_OR  = 4'b1001;
   localparam logic [3:0] OP_XOR = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   // True for the seven opcodes the ALU implements.
   function automatic logic is_legal_op(input logic [3:0] op);
      logic legal;
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR: legal = 1'b1;
         default:                                               legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Operand register file: two asynchronous read ports, one synchronous write port,
// synchronous clear on reset.
module alu_seq_regfile #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned REG_NUM = 4,
   localparam int unsigned IDX_W  = $clog2(REG_NUM)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [IDX_W-1:0]  rd_a_idx_i,
   input  logic [IDX_W-1:0]  rd_b_idx_i,
   output logic [DATA_W-1:0] rd_a_data_o,
   output logic [DATA_W-1:0] rd_b_data_o,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [DATA_W-1:0] wr_data_i
);

   logic [DATA_W-1:0] mem_q [REG_NUM];

   // Storage update: reset clears every entry and overrides any pending write.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < REG_NUM; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

   // Combinational read ports.
   always_comb begin
      rd_a_data_o = mem_q[rd_a_idx_i];
      rd_b_data_o = mem_q[rd_b_idx_i];
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side driver for the external 8-bit combinational ALU. Fetches operands,
// drives the ALU inputs for one cycle, writes the result back and returns it on a
// valid/ready response.
// Build option: define ALU_DIV_ZERO_CHECK_EN to reject DIV by zero (rspData all-ones,
// rspError set, no write) instead of issuing it to the ALU.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned REG_NUM = 4,
   localparam int unsigned IDX_W  = $clog2(REG_NUM)
) (
   input  logic              clk,
   input  logic              reset,
   // Command
   input  logic              cmdValid,
   output logic              cmdReady,
   input  logic [3:0]        cmdOp,
   input  logic [IDX_W-1:0]  cmdDst,
   input  logic [IDX_W-1:0]  cmdSrcA,
   input  logic [IDX_W-1:0]  cmdSrcB,
   input  logic              cmdUseImm,
   input  logic [DATA_W-1:0] cmdImm,
   // ALU interface
   output logic [DATA_W-1:0] firstInput,
   output logic [DATA_W-1:0] secondInput,
   output logic [3:0]        operation,
   input  logic [DATA_W-1:0] ALU_Out,
   input  logic              CarryOut,
   // Response
   output logic              rspValid,
   input  logic              rspReady,
   output logic [DATA_W-1:0] rspData,
   output logic              rspCarry,
   output logic              rspError
);

   state_e            state_q;
   logic [IDX_W-1:0]  dst_q;
   logic [DATA_W-1:0] first_q;
   logic [DATA_W-1:0] second_q;
   logic [3:0]        op_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_carry_q;
   logic              rsp_error_q;

   logic [DATA_W-1:0] rf_a_data;
   logic [DATA_W-1:0] rf_b_data;
   logic [DATA_W-1:0] operand_b;
   logic              rf_we;
   logic              div_reject;

   alu_seq_regfile #(
      .DATA_W  (DATA_W),
      .REG_NUM (REG_NUM)
   ) u_regfile (
      .clk_i       (clk),
      .reset_i     (reset),
      .rd_a_idx_i  (cmdSrcA),
      .rd_b_idx_i  (cmdSrcB),
      .rd_a_data_o (rf_a_data),
      .rd_b_data_o (rf_b_data),
      .wr_en_i     (rf_we),
      .wr_idx_i    (dst_q),
      .wr_data_i   (ALU_Out)
   );

   // Operand selection and write-back enable; the ALU result is valid throughout ISSUE.
   always_comb begin
      operand_b = cmdUseImm ? cmdImm : rf_b_data;
      rf_we     = (state_q == ST_ISSUE);
`ifdef ALU_DIV_ZERO_CHECK_EN
      div_reject = (cmdOp == OP_DIV) && (operand_b == '0);
`else
      div_reject = 1'b0;
`endif
   end

   // Sequencer FSM with registered ALU and response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         dst_q       <= '0;
         first_q     <= '0;
         second_q    <= '0;
         op_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
         rsp_error_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmdValid) begin
                  if (!is_legal_op(cmdOp)) begin
                     // Rejected: ALU ports keep their previous values.
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_carry_q <= 1'b0;
                     rsp_error_q <= 1'b1;
                     state_q     <= ST_RESP;
                  end else if (div_reject) begin
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= '1;
                     rsp_carry_q <= 1'b0;
                     rsp_error_q <= 1'b1;
                     state_q     <= ST_RESP;
                  end else begin
                     // Operands sampled here, so Dst==Src sees the old value.
                     first_q  <= rf_a_data;
                     second_q <= operand_b;
                     op_q     <= cmdOp;
                     dst_q    <= cmdDst;
                     state_q  <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= ALU_Out;
               rsp_carry_q <= CarryOut;
               rsp_error_q <= 1'b0;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rspReady) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Output drive.
   always_comb begin
      cmdReady    = (state_q == ST_IDLE);
      firstInput  = first_q;
      secondInput = second_q;
      operation   = op_q;
      rspValid    = rsp_valid_q;
      rspData     = rsp_data_q;
      rspCarry    = rsp_carry_q;
      rspError    = rsp_error_q;
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU stand-in.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmdValid;
   logic       cmdReady;
   logic [3:0] cmdOp;
   logic [1:0] cmdDst, cmdSrcA, cmdSrcB;
   logic       cmdUseImm;
   logic [7:0] cmdImm;
   logic [7:0] firstInput, secondInput;
   logic [3:0] operation;
   logic [7:0] ALU_Out;
   logic       CarryOut;
   logic       rspValid;
   logic       rspReady;
   logic [7:0] rspData;
   logic       rspCarry;
   logic       rspError;

   int n_checks = 0;
   int n_errors = 0;
   int ref_rf [4];

   always #5 clk = ~clk;

   alu_op_sequencer #(.DATA_W(8), .REG_NUM(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmdValid    (cmdValid),
      .cmdReady    (cmdReady),
      .cmdOp       (cmdOp),
      .cmdDst      (cmdDst),
      .cmdSrcA     (cmdSrcA),
      .cmdSrcB     (cmdSrcB),
      .cmdUseImm   (cmdUseImm),
      .cmdImm      (cmdImm),
      .firstInput  (firstInput),
      .secondInput (secondInput),
      .operation   (operation),
      .ALU_Out     (ALU_Out),
      .CarryOut    (CarryOut),
      .rspValid    (rspValid),
      .rspReady    (rspReady),
      .rspData     (rspData),
      .rspCarry    (rspCarry),
      .rspError    (rspError)
   );

   // ALU stand-in: division by zero returns 0, carry is always that of the add.
   always_comb begin
      logic [8:0] sum;
      sum = {1'b0, firstInput} + {1'b0, secondInput};
      CarryOut = sum[8];
      case (operation)
         4'b0000: ALU_Out = sum[7:0];
         4'b0001: ALU_Out = firstInput - secondInput;
         4'b0010: ALU_Out = firstInput * secondInput;
         4'b0011: ALU_Out = (secondInput == 8'd0) ? 8'd0 : firstInput / secondInput;
         4'b1000: ALU_Out = firstInput & secondInput;
         4'b1001: ALU_Out = firstInput | secondInput;
         4'b1010: ALU_Out = firstInput ^ secondInput;
         default: ALU_Out = 8'd0;
      endcase
   end

   function automatic bit tb_legal(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10};
   endfunction

   // Reference arithmetic on plain integers.
   function automatic int ref_alu(input logic [3:0] op, input int a, input int b);
      case (op)
         4'd0:    return (a + b) % 256;
         4'd1:    return (a - b + 256) % 256;
         4'd2:    return (a * b) % 256;
         4'd3:    return (b == 0) ? 0 : a / b;
         4'd8:    return a & b;
         4'd9:    return a | b;
         4'd10:   return a ^ b;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Waits (bounded) for rspValid; returns the number of extra edges needed.
   task automatic wait_resp(output int k);
      k = 0;
      while (!rspValid && k < 6) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   // One full command with rspReady held high. Expected values come from the table
   // when use_exp is set, otherwise from the reference model.
   task automatic run_cmd(input string name, input logic [3:0] op, input int dst, input int sa,
                          input int sb, input bit imm_en, input int imm, input bit use_exp,
                          input int e_data, input bit e_carry, input bit e_err);
      int ra, rb, res, k;
      bit legal, rej;
      logic [7:0] p1, p2;
      logic [3:0] pop;
      ra    = ref_rf[sa];
      rb    = imm_en ? imm : ref_rf[sb];
      legal = tb_legal(op);
`ifdef ALU_DIV_ZERO_CHECK_EN
      rej = legal && (op == 4'd3) && (rb == 0);
`else
      rej = 1'b0;
`endif
      res = ref_alu(op, ra, rb);
      if (!use_exp) begin
         e_err   = !legal || rej;
         e_data  = !legal ? 0 : (rej ? 255 : res);
         e_carry = legal && !rej && (ra + rb > 255);
      end
      p1  = firstInput;
      p2  = secondInput;
      pop = operation;
      chk({name, "/ready"}, cmdReady, 1);
      cmdValid  = 1'b1;
      cmdOp     = op;
      cmdDst    = dst[1:0];
      cmdSrcA   = sa[1:0];
      cmdSrcB   = sb[1:0];
      cmdUseImm = imm_en;
      cmdImm    = imm[7:0];
      @(posedge clk); #1;
      cmdValid = 1'b0;
      if (!legal) begin
         chk({name, "/first_hold"}, firstInput, p1);
         chk({name, "/second_hold"}, secondInput, p2);
         chk({name, "/op_hold"}, operation, pop);
      end else if (!rej) begin
         chk({name, "/first"}, firstInput, ra[7:0]);
         chk({name, "/second"}, secondInput, rb[7:0]);
         chk({name, "/op"}, operation, op);
      end
      wait_resp(k);
      chk({name, "/latency"}, k, e_err ? 0 : 1);
      chk({name, "/data"}, rspData, e_data[7:0]);
      chk({name, "/carry"}, rspCarry, e_carry);
      chk({name, "/error"}, rspError, e_err);
      if (legal && !rej) ref_rf[dst] = res;
      @(posedge clk); #1;
      chk({name, "/drop"}, rspValid, 0);
   endtask

   typedef struct {
      string      name;
      logic [3:0] op;
      int         dst, sa, sb;
      bit         imm_en;
      int         imm;
      int         e_data;
      bit         e_carry;
      bit         e_err;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int res, k;
      logic [3:0] op;

      tbl[0]  = '{"add200",  4'd0,  1, 0, 0, 1, 200, 200,  0, 0};
      tbl[1]  = '{"add100",  4'd0,  2, 1, 0, 1, 100, 44,   1, 0};
      tbl[2]  = '{"sub50",   4'd1,  3, 2, 0, 1, 50,  250,  0, 0};
      tbl[3]  = '{"set16",   4'd0,  1, 0, 0, 1, 16,  16,   0, 0};
      tbl[4]  = '{"mulwrap", 4'd2,  1, 1, 1, 0, 0,   0,    0, 0};
      tbl[5]  = '{"illegal", 4'd4,  2, 0, 0, 1, 9,   0,    0, 1};
      tbl[6]  = '{"rd_r2",   4'd9,  2, 2, 0, 1, 0,   44,   0, 0};
      tbl[7]  = '{"and_reg", 4'd8,  3, 3, 2, 0, 0,   8'h28, 1, 0};
      tbl[8]  = '{"xor_ff",  4'd10, 0, 3, 0, 1, 255, 8'hD7, 1, 0};
`ifdef ALU_DIV_ZERO_CHECK_EN
      tbl[9]  = '{"div0",    4'd3,  2, 2, 0, 1, 0,   255,  0, 1};
      tbl[10] = '{"rd_div0", 4'd9,  2, 2, 0, 1, 0,   44,   0, 0};
`else
      tbl[9]  = '{"div0",    4'd3,  2, 2, 0, 1, 0,   0,    0, 0};
      tbl[10] = '{"rd_div0", 4'd9,  2, 2, 0, 1, 0,   0,    0, 0};
`endif
      tbl[11] = '{"div5",    4'd3,  1, 3, 0, 1, 5,   8,    0, 0};

      reset     = 1'b1;
      cmdValid  = 1'b0;
      cmdOp     = '0;
      cmdDst    = '0;
      cmdSrcA   = '0;
      cmdSrcB   = '0;
      cmdUseImm = 1'b0;
      cmdImm    = '0;
      rspReady  = 1'b1;
      for (int i = 0; i < 4; i++) ref_rf[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst/ready", cmdReady, 1);
      chk("rst/valid", rspValid, 0);
      chk("rst/first", firstInput, 0);
      chk("rst/second", secondInput, 0);
      chk("rst/op", operation, 0);
      chk("rst/data", rspData, 0);
      chk("rst/err", rspError, 0);

      // Directed table
      for (int i = 0; i < 12; i++) begin
         run_cmd(tbl[i].name, tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb, tbl[i].imm_en,
                 tbl[i].imm, 1'b1, tbl[i].e_data, tbl[i].e_carry, tbl[i].e_err);
      end

      // Randomized commands against the reference model
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 9);
         case (k)
            0: op = 4'd0;
            1: op = 4'd1;
            2: op = 4'd2;
            3: op = 4'd3;
            4: op = 4'd8;
            5: op = 4'd9;
            6: op = 4'd10;
            default: begin
               op = 4'($urandom_range(4, 15));
               if (op inside {4'd8, 4'd9, 4'd10}) op = op + 4'd3;
            end
         endcase
         run_cmd("rand", op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255),
                 1'b0, 0, 1'b0, 1'b0);
      end

      // Back-pressure: response held while rspReady is low, queued command waits.
      rspReady  = 1'b0;
      res       = (ref_rf[0] + 1) % 256;
      cmdValid  = 1'b1;
      cmdOp     = 4'd0;
      cmdDst    = 2'd0;
      cmdSrcA   = 2'd0;
      cmdUseImm = 1'b1;
      cmdImm    = 8'd1;
      @(posedge clk); #1;
      cmdValid = 1'b0;
      @(posedge clk); #1;
      chk("bp/valid", rspValid, 1);
      chk("bp/data", rspData, res[7:0]);
      ref_rf[0] = res;
      cmdValid  = 1'b1;
      cmdOp     = 4'd9;
      cmdDst    = 2'd1;
      cmdSrcA   = 2'd0;
      cmdImm    = 8'd0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp/hold_valid", rspValid, 1);
         chk("bp/hold_data", rspData, res[7:0]);
         chk("bp/hold_ready", cmdReady, 0);
      end
      rspReady = 1'b1;
      @(posedge clk); #1;
      chk("bp/hs_valid", rspValid, 0);
      chk("bp/hs_ready", cmdReady, 1);
      @(posedge clk); #1;
      cmdValid = 1'b0;
      chk("bp/accept", cmdReady, 0);
      chk("bp/accept_first", firstInput, res[7:0]);
      wait_resp(k);
      chk("bp/second_lat", k, 1);
      chk("bp/second_data", rspData, res[7:0]);
      ref_rf[1] = res;
      @(posedge clk); #1;

      // Reset during ISSUE drops the command.
      run_cmd("seed", 4'd0, 3, 0, 0, 1, 77, 1'b0, 0, 1'b0, 1'b0);
      cmdValid  = 1'b1;
      cmdOp     = 4'd0;
      cmdDst    = 2'd2;
      cmdSrcA   = 2'd3;
      cmdUseImm = 1'b1;
      cmdImm    = 8'd7;
      @(posedge clk); #1;
      cmdValid = 1'b0;
      chk("rsti/in_issue", cmdReady, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rsti/valid", rspValid, 0);
      chk("rsti/ready", cmdReady, 1);
      chk("rsti/first", firstInput, 0);
      chk("rsti/second", secondInput, 0);
      chk("rsti/op", operation, 0);
      chk("rsti/data", rspData, 0);
      for (int i = 0; i < 4; i++) ref_rf[i] = 0;
      for (int i = 0; i < 4; i++) begin
         run_cmd("rsti/rf", 4'd9, i, i, 0, 1, 0, 1'b1, 0, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
